// File: rtl/elpis_print_pkg.sv
// Shared register map and bit positions for the Elpis print port.
package elpis_print_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h3000_0000;

  localparam logic [3:0] STATUS_OFF = 4'h0;
  localparam logic [3:0] DATA_OFF   = 4'h4;
  localparam logic [3:0] CTRL_OFF   = 4'h8;

  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_UNDERFLOW = 2;
  localparam int ST_COUNT_LSB = 8;

  localparam int CTRL_FLUSH  = 0;
  localparam int CTRL_CLR_UF = 1;

  function automatic logic [31:0] status_word(input logic not_empty, input logic full,
                                              input logic underflow, input logic [7:0] count);
    status_word = '0;
    status_word[ST_NOT_EMPTY] = not_empty;
    status_word[ST_FULL] = full;
    status_word[ST_UNDERFLOW] = underflow;
    status_word[ST_COUNT_LSB +: 8] = count;
  endfunction

endpackage

// File: rtl/print_fifo.sv
// Synchronous FIFO of 32-bit print words with flush and a registered not-empty flag.
module print_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          pending
);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_nxt;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Flush has priority over a same-cycle push: the word is dropped.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pending <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      count   <= count_nxt;
      pending <= (count_nxt != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/elpis_print_port.sv
// Print word channel from the Elpis core to Caravel firmware: FIFO plus a
// Wishbone slave with STATUS / DATA / CTRL registers.
module elpis_print_port
  import elpis_print_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        print_valid,
  input  logic [31:0] print_data,
  output logic        print_ready,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        print_pending
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic [31:0]   head;
  logic [3:0]    off;
  logic          req;
  logic          data_rd;
  logic          ctrl_wr;
  logic          flush;
  logic          clr_uf;
  logic          underflow;
  logic [31:0]   rd_word;
  logic          unused;

  assign unused = ^{wbs_sel_i[3:1], wbs_dat_i[31:2]};

  // Gating on !wbs_ack_o keeps a held strobe from issuing a back-to-back access.
  assign off     = wbs_adr_i[3:0];
  assign req     = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:4] == BASE_ADDR[31:4]) && !wbs_ack_o;
  assign data_rd = req && !wbs_we_i && (off == DATA_OFF);
  assign ctrl_wr = req && wbs_we_i && (off == CTRL_OFF) && wbs_sel_i[0];
  assign flush   = ctrl_wr && wbs_dat_i[CTRL_FLUSH];
  assign clr_uf  = ctrl_wr && wbs_dat_i[CTRL_CLR_UF];

  print_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .push    (print_valid),
    .pop     (data_rd),
    .flush   (flush),
    .wdata   (print_data),
    .rdata   (head),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .pending (print_pending)
  );

  assign print_ready = !full;

  always_comb begin
    rd_word = '0;
    if (!wbs_we_i) begin
      case (off)
        STATUS_OFF: rd_word = status_word(!empty, full, underflow, 8'(count));
        DATA_OFF:   rd_word = empty ? '0 : head;
        default:    rd_word = '0;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      underflow <= 1'b0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= req ? rd_word : '0;
      if (data_rd && empty) underflow <= 1'b1;
      else if (clr_uf) underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_elpis_print_port.sv
// Scoreboarded bench for elpis_print_port: queue-based reference model, random and directed traffic.
module tb_elpis_print_port;

  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h3000_0000;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        print_valid = 1'b0;
  logic [31:0] print_data = '0;
  logic        print_ready;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = '0;
  logic [31:0] wbs_adr_i = '0;
  logic [31:0] wbs_dat_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        print_pending;

  elpis_print_port #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_i      (wb_rst_i),
    .print_valid   (print_valid),
    .print_data    (print_data),
    .print_ready   (print_ready),
    .wbs_cyc_i     (wbs_cyc_i),
    .wbs_stb_i     (wbs_stb_i),
    .wbs_we_i      (wbs_we_i),
    .wbs_sel_i     (wbs_sel_i),
    .wbs_adr_i     (wbs_adr_i),
    .wbs_dat_i     (wbs_dat_i),
    .wbs_ack_o     (wbs_ack_o),
    .wbs_dat_o     (wbs_dat_o),
    .print_pending (print_pending)
  );

  // ---------------- clock ----------------
  always #5 wb_clk_i = ~wb_clk_i;

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // The FIFO is a plain queue; STATUS is rebuilt from its size and the sticky flag.
  logic [31:0] mq[$];
  bit          m_uf = 1'b0;
  bit          m_ack = 1'b0;
  logic [31:0] exp_q[$];
  bit          kind_q[$];
  bit          m_req, m_push, m_flush;
  logic [31:0] m_rv;

  always @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      mq.delete();
      exp_q.delete();
      kind_q.delete();
      m_uf = 1'b0;
      m_ack = 1'b0;
    end else begin
      m_req = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:4] == BASE[31:4]) && !m_ack;
      m_push = print_valid && (mq.size() < DEPTH);
      m_flush = 1'b0;
      if (m_req) begin
        kind_q.push_back(!wbs_we_i);
        if (!wbs_we_i) begin
          m_rv = '0;
          if (wbs_adr_i[3:0] == 4'h0)
            m_rv = {16'h0, 8'(mq.size()), 5'h0, m_uf, mq.size() == DEPTH, mq.size() != 0};
          else if (wbs_adr_i[3:0] == 4'h4) begin
            if (mq.size() > 0) m_rv = mq.pop_front();
            else m_uf = 1'b1;
          end
          exp_q.push_back(m_rv);
        end else if (wbs_adr_i[3:0] == 4'h8 && wbs_sel_i[0]) begin
          if (wbs_dat_i[0]) m_flush = 1'b1;
          if (wbs_dat_i[1]) m_uf = 1'b0;
        end
      end
      if (m_flush) mq.delete();
      else if (m_push) mq.push_back(print_data);
      m_ack = m_req;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge wb_clk_i) begin
    if (started && !wb_rst_i) begin
      if (wbs_ack_o) begin
        if (kind_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack: got ack=1 expected no ack");
        end else if (kind_q.pop_front()) begin
          check("read_data", wbs_dat_o, exp_q.pop_front());
        end
      end else begin
        check("dat_idle_zero", wbs_dat_o, 32'h0);
      end
      check("print_ready", {31'h0, print_ready}, {31'h0, mq.size() < DEPTH});
      check("print_pending", {31'h0, print_pending}, {31'h0, mq.size() != 0});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wb_access(input logic we, input logic [31:0] addr, input logic [31:0] d,
                           input logic [3:0] sel, input bit expect_ack, output logic [31:0] rd);
    int n;
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = addr; wbs_dat_i = d; wbs_sel_i = sel;
    n = 0;
    rd = '0;
    do begin
      @(negedge wb_clk_i);
      n++;
    end while (!wbs_ack_o && n < 6);
    if (expect_ack) begin
      if (!wbs_ack_o) begin
        checks++;
        failures++;
        $display("FAIL ack_timeout: got no ack expected ack at addr 0x%08h", addr);
      end
      rd = wbs_dat_o;
    end else begin
      check("no_ack_foreign", {31'h0, wbs_ack_o}, 32'h0);
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wb_read(input logic [3:0] off, output logic [31:0] rd);
    wb_access(1'b0, BASE | 32'(off), 32'h0, 4'hf, 1'b1, rd);
  endtask

  task automatic wb_write(input logic [3:0] off, input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] dummy;
    wb_access(1'b1, BASE | 32'(off), d, sel, 1'b1, dummy);
  endtask

  task automatic push_word(input logic [31:0] d);
    int n;
    @(negedge wb_clk_i);
    print_valid = 1'b1;
    print_data = d;
    n = 0;
    while (!print_ready && n < 50) begin
      @(negedge wb_clk_i);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL push_timeout: got ready=0 expected ready within 50 cycles");
    end
    @(negedge wb_clk_i);
    print_valid = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  logic [31:0] rd;
  logic [31:0] rnd;
  bit          rand_done;

  initial begin
    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    started = 1'b1;
    check("rst_ack", {31'h0, wbs_ack_o}, 32'h0);
    check("rst_dat", wbs_dat_o, 32'h0);
    check("rst_pending", {31'h0, print_pending}, 32'h0);
    check("rst_ready", {31'h0, print_ready}, 32'h1);

    // Single word round trip
    push_word(32'd2);
    check("pending_after_push", {31'h0, print_pending}, 32'h1);
    wb_read(4'h0, rd);
    check("status_one", rd, 32'h0000_0101);
    wb_read(4'h4, rd);
    check("data_two", rd, 32'd2);
    check("pending_after_pop", {31'h0, print_pending}, 32'h0);

    // Fill to full, stall the ninth word behind one read
    for (int i = 1; i <= DEPTH; i++) push_word(32'(i));
    check("ready_full", {31'h0, print_ready}, 32'h0);
    wb_read(4'h0, rd);
    check("status_full", rd, 32'h0000_0803);
    fork
      push_word(32'd9);
      begin
        repeat (2) @(negedge wb_clk_i);
        check("ready_stall", {31'h0, print_ready}, 32'h0);
        wb_read(4'h4, rd);
        check("data_first", rd, 32'd1);
      end
    join
    for (int i = 2; i <= 9; i++) begin
      wb_read(4'h4, rd);
      check("data_order", rd, 32'(i));
    end

    // Underflow sticky and its clear
    wb_read(4'h4, rd);
    check("data_empty", rd, 32'h0);
    wb_read(4'h0, rd);
    check("status_uf", rd, 32'h0000_0004);
    wb_write(4'h8, 32'h2, 4'h1);
    wb_read(4'h0, rd);
    check("status_uf_clr", rd, 32'h0);

    // Push into empty FIFO while a DATA read pops in the same cycle
    rnd = $urandom;
    fork
      push_word(rnd);
      wb_read(4'h4, rd);
    join
    check("empty_pushpop_rd", rd, 32'h0);
    wb_read(4'h0, rd);
    check("empty_pushpop_status", rd, 32'h0000_0105);
    wb_read(4'h4, rd);
    check("empty_pushpop_word", rd, rnd);
    wb_write(4'h8, 32'h2, 4'h1);

    // Steady push+pop at count 3, crossing the pointer wrap
    for (int i = 0; i < 3; i++) push_word($urandom);
    for (int i = 0; i < 10; i++) begin
      fork
        push_word($urandom);
        wb_read(4'h4, rd);
      join
    end
    wb_read(4'h0, rd);
    check("status_steady3", rd, 32'h0000_0301);
    for (int i = 0; i < 3; i++) wb_read(4'h4, rd);

    // Flush: ignored without sel[0], honoured with it
    for (int i = 0; i < 5; i++) push_word($urandom);
    wb_write(4'h8, 32'h1, 4'he);
    wb_read(4'h0, rd);
    check("status_flush_nosel", rd, 32'h0000_0501);
    wb_write(4'h8, 32'h1, 4'h1);
    check("pending_flush", {31'h0, print_pending}, 32'h0);
    wb_read(4'h0, rd);
    check("status_flushed", rd, 32'h0);
    wb_read(4'h4, rd);
    check("data_after_flush", rd, 32'h0);
    wb_read(4'h0, rd);
    check("status_flush_uf", rd, 32'h0000_0004);
    wb_write(4'h8, 32'h2, 4'h1);

    // Flush beats a same-cycle push
    fork
      push_word(32'hdead_beef);
      wb_write(4'h8, 32'h1, 4'h1);
    join
    wb_read(4'h0, rd);
    check("status_flush_push", rd, 32'h0);

    // Unmapped offset and foreign address
    push_word(32'h1234_5678);
    wb_read(4'hc, rd);
    check("unmapped_read", rd, 32'h0);
    wb_write(4'h4, 32'hffff_ffff, 4'hf);
    wb_access(1'b0, 32'h3000_0104, 32'h0, 4'hf, 1'b0, rd);
    wb_read(4'h4, rd);
    check("data_after_foreign", rd, 32'h1234_5678);

    // Random concurrent traffic
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          case ($urandom_range(0, 7))
            0, 1, 2, 3: wb_read(4'h4, rd);
            4:          wb_read(4'h0, rd);
            5:          wb_read(4'hc, rd);
            6:          wb_write(4'h8, 32'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            default:    wb_write(4'(4 * $urandom_range(0, 3)), $urandom, 4'hf);
          endcase
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(negedge wb_clk_i);
          print_valid = 1'($urandom_range(0, 1));
          print_data = $urandom;
        end
        print_valid = 1'b0;
      end
    join

    // Reset in the middle of a DATA request with words queued
    wb_write(4'h8, 32'h3, 4'h1);
    for (int i = 0; i < 4; i++) push_word($urandom);
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = BASE | 32'h4; wbs_sel_i = 4'hf;
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    check("midrst_ack", {31'h0, wbs_ack_o}, 32'h0);
    check("midrst_dat", wbs_dat_o, 32'h0);
    check("midrst_pending", {31'h0, print_pending}, 32'h0);
    check("midrst_ready", {31'h0, print_ready}, 32'h1);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    check("postrst_ready", {31'h0, print_ready}, 32'h1);
    wb_read(4'h0, rd);
    check("postrst_status", rd, 32'h0);

    repeat (2) @(negedge wb_clk_i);
    check("pending_acks", 32'(kind_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/elpis_print_port.md
Name: elpis_print_port

Overview:
- Output channel between the Elpis core's print path and the Caravel management SoC.
- Buffers 32-bit print words issued by the core in a small FIFO.
- Raises a pending flag that the top level drives onto la_data_out[100].
- The management firmware drains the words through a Wishbone slave (STATUS/DATA/CTRL registers), producing the wbs_dat_o values the print tests check.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- BASE_ADDR, 32'h3000_0000, Wishbone base address; registers at BASE+0x0 STATUS, +0x4 DATA, +0x8 CTRL.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset, synchronous, active-high
- print_valid  in  1  core presents print word
- print_data  in  32  print word
- print_ready  out  1  FIFO can accept; core stalls while low
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte select; ignored except CTRL byte 0
- wbs_adr_i  in  32  address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- print_pending  out  1  FIFO not empty; drives la_data_out[100]

Behaviour:
- Reset (wb_rst_i sampled high on a wb_clk_i edge) clears state as follows:
  - FIFO count and pointers = 0, underflow sticky = 0.
  - wbs_ack_o = 0, wbs_dat_o = 0, print_pending = 0, print_ready = 1 after reset.
  - Reset mid-transaction discards all buffered words and aborts any pending ack.
- Push:
  - Occurs when print_valid && print_ready at a clock edge.
  - print_ready = !full; it is combinational from registered count only, so there is no dependency on the same-cycle pop.
  - When full and a pop occurs in the same cycle, the push is not taken. print_ready rises on the next cycle.
- Pop: occurs on an acknowledged DATA read while count > 0.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both take effect.
- Empty-push and pop same cycle: the pop sees empty. The read returns 0 and sets underflow; the pushed word is retained.
- Wishbone:
  - A request is wbs_cyc_i && wbs_stb_i && addr matches BASE_ADDR[31:4] && !wbs_ack_o.
  - Ack is a one-cycle pulse on the edge after the request; minimum 2 cycles per access.
  - wbs_dat_o is registered with the ack and returns to 0 the cycle after.
  - Non-matching addresses get no ack.
  - Unmapped offsets inside the window (0xC) ack with data 0; writes to them are ignored.
- STATUS (read-only):
  - bit0 = not empty
  - bit1 = full
  - bit2 = underflow sticky
  - bits[15:8] = count
  - others 0
- DATA:
  - Read returns the head word and pops.
  - Read when empty returns 0, no pop, sets underflow.
  - Write ignored, but acked.
- CTRL (write-only, reads 0), honoured only if wbs_sel_i[0]:
  - bit0 = flush FIFO (count/pointers to 0).
  - bit1 = clear underflow.
  - Flush and same-cycle push: flush wins, the word is dropped, and print_ready was high, so the core sees it as accepted.
- print_pending = registered (count != 0); it updates the edge after the push/pop.
- Pointer wrap: log2(DEPTH)-bit pointers wrap modulo DEPTH. Count is log2(DEPTH)+1 bits; full = (count == DEPTH).
- Latency: a word pushed at edge N is visible in STATUS/print_pending from edge N+1 and is readable by a DATA access requested at N+1.

Decomposition:
- Shared package elpis_print_pkg:
  - register offsets (STATUS_OFF, DATA_OFF, CTRL_OFF)
  - STATUS/CTRL bit indices
  - DEFAULT_BASE_ADDR
- Sub-module print_fifo (sync FIFO: push/pop/flush, full/empty/count).
- The top contains the Wishbone decode/ack logic and the status register.

Test Plan:
- Core pushes 32'd2 after reset.
  - print_pending rises next cycle.
  - STATUS read = 0x0000_0101.
  - DATA read returns wbs_dat_o = 2 with a one-cycle ack.
  - print_pending then falls.
- Push 1..DEPTH (8).
  - print_ready low, STATUS = 0x0000_0803.
  - Ninth word stalls until one DATA read returns 1.
  - Next push accepted; subsequent reads return 2..9 in order.
- DATA read while empty.
  - Returns 0, STATUS bit2 = 1.
  - CTRL write 0x2 clears it; STATUS returns 0.
- Continuous push and pop at count = 3 over 20 cycles.
  - Count stays 3, no data loss or reorder, across a pointer wrap.
- CTRL write 0x1 with 5 words queued.
  - Count 0, print_pending 0 next cycle.
  - DATA read returns 0 and sets underflow.
- Assert wb_rst_i mid DATA request with 4 words queued.
  - No ack, all outputs at reset values, count 0.
  - print_ready = 1 the cycle after reset deasserts.
